// File: rtl/modem_defs.sv
// Shared definitions for the line-side modem blocks.
// State encodings and framing constants used by TX and RX.
package modem_defs;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
        CRC      = 3'd4,
        GAP      = 3'd5
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // Index of the stop bit within a 10-bit character.
    localparam logic [3:0] BIT_LAST      = 4'd9;

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC-8 update, MSB first, no reflection.
// Purely combinational; shared with the RX deframer.
module crc8_byte
    import modem_defs::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] w_c;

    // Fold the byte in, then clock the register eight times.
    always_comb begin
        w_c = crc_i ^ data_i;
        for (int i = 0; i < 8; i++) begin
            if (w_c[7]) begin
                w_c = {w_c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                w_c = {w_c[6:0], 1'b0};
            end
        end
        crc_o = w_c;
    end

endmodule

// File: rtl/tx_framer.sv
// Transmit framer: preamble, SFD, payload, CRC-8, idle gap.
// Serialises bytes as 10-bit UART characters, LSB first.
module tx_framer
    import modem_defs::*;
#(
    parameter int BIT_DIV      = 4,
    parameter int PREAMBLE_LEN = 2,
    parameter int GAP_BITS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       begin_i,
    input  logic       valid_i,
    input  logic       end_i,
    output logic       ready_o,
    output logic       line_o,
    output logic       busy_o,
    output logic       clk_req_o,
    output logic       frame_done_o,
    output logic       err_o
);

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [9:0] r_shift;
    logic [7:0] r_div;
    logic [3:0] r_bit;
    logic [3:0] r_cnt;
    logic [7:0] r_crc;
    logic       r_last;
    logic       r_sending;

    logic       w_bit_end;
    logic       w_byte_end;
    logic       w_slot;
    logic       w_ld;
    logic [7:0] w_ld_byte;
    logic       w_stop;
    logic       w_crc_we;
    logic       w_cnt_inc;
    logic       w_cnt_clr;
    logic [7:0] w_crc_base;
    logic [7:0] w_crc_nxt;

    assign w_bit_end  = (r_div == DIV_LAST);
    assign w_byte_end = r_sending && w_bit_end && (r_bit == BIT_LAST);

    // The first payload byte is folded into a freshly cleared CRC.
    assign w_crc_base = (r_state == SFD) ? 8'h00 : r_crc;

    crc8_byte u_crc (
        .crc_i  (w_crc_base),
        .data_i (byte_i),
        .crc_o  (w_crc_nxt)
    );

    assign line_o    = r_sending ? r_shift[0] : 1'b1;
    assign busy_o    = (r_state != IDLE);
    assign clk_req_o = busy_o | valid_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, advancing on character and gap boundaries.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (valid_i && begin_i) w_state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (w_byte_end && r_cnt == PRE_LAST) w_state_nxt = SFD;
            end
            SFD: begin
                if (w_byte_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_byte_end && r_last) w_state_nxt = CRC;
            end
            CRC: begin
                if (w_byte_end) w_state_nxt = GAP;
            end
            GAP: begin
                if (w_bit_end && r_cnt == GAP_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs and datapath controls; the payload slot opens in the
    // last stop-bit cycle so back-to-back bytes leave no idle bit.
    always_comb begin
        ready_o      = 1'b0;
        err_o        = 1'b0;
        frame_done_o = 1'b0;
        w_slot       = 1'b0;
        w_ld         = 1'b0;
        w_ld_byte    = 8'hFF;
        w_stop       = 1'b0;
        w_crc_we     = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (valid_i && begin_i) begin
                    w_ld      = 1'b1;
                    w_ld_byte = PREAMBLE_BYTE;
                    w_cnt_clr = 1'b1;
                end else if (valid_i) begin
                    ready_o = 1'b1;
                    err_o   = 1'b1;
                end
            end
            PREAMBLE: begin
                if (w_byte_end) begin
                    w_ld = 1'b1;
                    if (r_cnt == PRE_LAST) begin
                        w_ld_byte = SFD_BYTE;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_ld_byte = PREAMBLE_BYTE;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            SFD: begin
                w_slot = w_byte_end;
                if (w_slot && valid_i) begin
                    ready_o   = 1'b1;
                    w_ld      = 1'b1;
                    w_ld_byte = byte_i;
                    w_crc_we  = 1'b1;
                end else if (w_byte_end) begin
                    w_stop = 1'b1;
                end
            end
            DATA: begin
                w_slot = !r_sending || (w_byte_end && !r_last);
                if (w_slot && valid_i) begin
                    ready_o   = 1'b1;
                    w_ld      = 1'b1;
                    w_ld_byte = byte_i;
                    w_crc_we  = 1'b1;
                end else if (w_byte_end) begin
                    if (r_last) begin
                        w_ld      = 1'b1;
                        w_ld_byte = r_crc;
                    end else begin
                        w_stop = 1'b1;
                    end
                end
            end
            CRC: begin
                if (w_byte_end) begin
                    w_stop    = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            GAP: begin
                if (w_bit_end) begin
                    if (r_cnt == GAP_LAST) begin
                        frame_done_o = 1'b1;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_stop = 1'b1;
            end
        endcase
    end

    // Shifter, bit pacing, byte/gap counter and CRC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '1;
            r_div     <= '0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_last    <= 1'b0;
            r_sending <= 1'b0;
        end else begin
            if (w_ld) begin
                r_shift   <= {1'b1, w_ld_byte, 1'b0};
                r_div     <= '0;
                r_bit     <= '0;
                r_sending <= 1'b1;
            end else if (w_stop) begin
                r_shift   <= '1;
                r_div     <= '0;
                r_bit     <= '0;
                r_sending <= 1'b0;
            end else if (r_sending || r_state == GAP) begin
                if (w_bit_end) begin
                    r_div   <= '0;
                    r_shift <= {1'b1, r_shift[9:1]};
                    r_bit   <= (r_bit == BIT_LAST) ? 4'd0 : r_bit + 4'd1;
                end else begin
                    r_div <= r_div + 8'd1;
                end
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_crc_we) begin
                r_crc  <= w_crc_nxt;
                r_last <= end_i;
            end else if (r_state == SFD) begin
                r_crc <= 8'h00;
            end
        end
    end

endmodule

// File: doc/tx_framer.md
# tx_framer

Line-side transmit framer sitting directly downstream of the TX ring-buffer controller. It consumes the controller's byte stream (byte/begin/valid/end with a ready strobe) and serialises each message onto a single-bit line as a UART-style frame: preamble, start-of-frame delimiter, payload, then a CRC-8 trailer. It replaces the free-running ready divider as the byte pacing source and provides clock-request and busy status to the top level.

## Interface
- BIT_DIV, 4: clock cycles per line bit; legal values are 2..255.
- PREAMBLE_LEN, 2: number of 0x55 preamble bytes; legal values are 1..15.
- GAP_BITS, 4: idle-high bit times inserted after the CRC byte; legal values are 1..15.
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- byte_i  in  8  payload byte from the TX controller.
- begin_i  in  1  qualifies byte_i as the first byte of a message.
- valid_i  in  1  byte_i is valid.
- end_i  in  1  qualifies byte_i as the last byte of a message. May coincide with begin_i.
- ready_o  out  1  byte consumed this cycle.
- line_o  out  1  serial line output, idle high.
- busy_o  out  1  a frame is in progress (any state other than IDLE).
- clk_req_o  out  1  equals busy_o | valid_i.
- frame_done_o  out  1  one-cycle pulse when the frame gap completes.
- err_o  out  1  one-cycle pulse when a byte without begin_i is dropped in IDLE.

## Operation
- Reset values: line_o=1, busy_o=0, ready_o=0, frame_done_o=0, err_o=0. State returns to IDLE; counters and CRC are cleared.
- Every byte is sent as 10 bits, LSB first: start bit 0, then 8 data bits, then stop bit 1. Each bit is held for BIT_DIV cycles.
- State machine: IDLE -> PREAMBLE -> SFD -> DATA -> CRC -> GAP -> IDLE.
- IDLE:
  - valid_i & begin_i: enter PREAMBLE. The byte is not consumed yet.
  - valid_i & !begin_i: the byte is consumed and dropped. ready_o=1 and err_o=1 in that cycle.
- PREAMBLE: send PREAMBLE_LEN bytes of 0x55, then go to SFD.
- SFD: send 0xD5. Clear the CRC register to 0x00. Enter DATA with the load slot open.
- DATA:
  - While the load slot is open, ready_o = valid_i, driven combinationally from registered state and valid_i.
  - On the cycle ready_o=1: load byte_i into the shifter, update the CRC, latch end_i, and close the slot. The start bit appears on line_o the next cycle.
  - The slot reopens in the last cycle of the stop bit.
  - Underrun (slot open, valid_i=0): line_o stays 1 until valid_i arrives.
  - After the stop bit of a byte latched with end_i=1: go to CRC. The slot stays closed.
- CRC: send the CRC register value, then go to GAP.
- GAP: hold line_o=1 for GAP_BITS bit times. Pulse frame_done_o in the final cycle, then return to IDLE.
- begin_i is ignored outside IDLE. A byte with begin_i in DATA is treated as payload.
- CRC-8: polynomial 0x07, initial value 0x00, MSB-first, no reflection, no final XOR. It covers payload bytes only.
- Reset mid-frame: line_o=1 in the cycle after rst is sampled. No partial CRC byte is sent.

## Timing
- IDLE with valid_i & begin_i sampled at cycle t: line_o=0 (first preamble start bit) at t+1.
- Payload byte accepted at cycle t: its start bit occupies cycles t+1 .. t+BIT_DIV.
- With no underrun, the total frame is (PREAMBLE_LEN+2+N)·10·BIT_DIV cycles, plus GAP_BITS·BIT_DIV cycles of gap. N is the payload length.
- Back-to-back bytes: consecutive ready_o pulses are exactly 10·BIT_DIV cycles apart.
- Bit counter is 4 bits, modulo 10. The divider is 8 bits. No other counter wraps within a frame.

## Structure
- Shared package/include modem_defs holds:
  - state encodings: IDLE, PREAMBLE, SFD, DATA, CRC, GAP
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC8_POLY=8'h07
- Sub-module crc8_byte: combinational, crc_i[7:0], data_i[7:0] -> crc_o[7:0]. It is reused later by the RX deframer.

## Test plan
- BIT_DIV=4, PREAMBLE_LEN=2, single byte 0x41 (begin_i=end_i=1): line sends 0x55, 0x55, 0xD5, 0x41, 0xC0. ready_o pulses exactly once, at cycle t+120. frame_done_o fires at cycle t+200+16.
- Message "AB", valid_i held high: two ready_o pulses 40 cycles apart. CRC byte = CRC-8 of {0x41,0x42}, computed by the reference model.
- Underrun: withhold the second byte for 37 cycles. line_o stays high during the wait. The start bit follows 1 cycle after ready_o, and the CRC is unchanged versus the no-gap run.
- In IDLE, valid_i=1 and begin_i=0 with byte 0x33: ready_o=1 and err_o=1 for one cycle. line_o stays 1 and busy_o stays 0.
- Assert rst during a payload data bit: line_o=1 and busy_o=0 on the next cycle. A following message is framed correctly from its preamble.
- clk_req_o tracks busy_o | valid_i every cycle. It is 0 after frame_done_o when no valid_i is pending.
